// File: rtl/layer_output_serializer_if.sv
// Handshake bundle between a neuron layer's parallel output and the serial stream
// feeding the next layer.
interface layer_output_serializer_if #(
  parameter int unsigned NEURON_NUMBER = 10,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned IDX_W         = $clog2(NEURON_NUMBER)
);
  logic                                in_valid;
  logic                                in_ready;
  logic [NEURON_NUMBER*DATA_WIDTH-1:0] in_data;
  logic                                out_valid;
  logic                                out_ready;
  logic [DATA_WIDTH-1:0]               out_data;
  logic [IDX_W-1:0]                    out_index;
  logic                                out_last;
  logic                                busy;
  logic [7:0]                          frame_count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, busy, frame_count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, busy, frame_count
  );
endinterface

// File: rtl/layer_output_serializer.sv
// Captures a layer's flat output vector in one handshake and streams it word by word,
// neuron 0 first, with optional ReLU, element index, last flag and a frame counter.
module layer_output_serializer #(
  parameter int unsigned NEURON_NUMBER = 10,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter bit          RELU_EN       = 1'b1,
  parameter int unsigned IDX_W         = $clog2(NEURON_NUMBER)
) (
  input logic                     clk,
  input logic                     rst_n,
  layer_output_serializer_if.slave bus
);
  localparam int unsigned      VecW    = NEURON_NUMBER * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NEURON_NUMBER - 1);

  typedef enum logic {StIdle, StStream} state_e;

  state_e                r_state;
  logic [VecW-1:0]       r_buf;
  logic [IDX_W-1:0]      r_index;
  logic [7:0]            r_frame;
  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0] w_relu;
  logic                  w_stream;
  logic                  w_last;

  // The buffer shifts down each transfer, so the current word is always the low slice.
  assign w_word   = r_buf[DATA_WIDTH-1:0];
  assign w_relu   = (RELU_EN && w_word[DATA_WIDTH-1]) ? '0 : w_word;
  assign w_stream = (r_state == StStream);
  assign w_last   = (r_index == LastIdx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_buf   <= '0;
      r_index <= '0;
      r_frame <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_buf   <= bus.in_data;
            r_index <= '0;
            r_state <= StStream;
          end
        end
        StStream: begin
          if (bus.out_ready) begin
            if (w_last) begin
              r_state <= StIdle;
              r_frame <= r_frame + 8'd1;
            end else begin
              r_index <= r_index + 1'b1;
              r_buf   <= r_buf >> DATA_WIDTH;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Outputs are gated so IDLE always presents reset-style values.
  assign bus.in_ready    = (r_state == StIdle);
  assign bus.out_valid   = w_stream;
  assign bus.busy        = w_stream;
  assign bus.out_data    = w_stream ? w_relu : '0;
  assign bus.out_index   = w_stream ? r_index : '0;
  assign bus.out_last    = w_stream && w_last;
  assign bus.frame_count = r_frame;
endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed bench for layer_output_serializer: one instance without ReLU, one with,
// driven in lockstep from shared stimulus.
module tb_layer_output_serializer;
  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = $clog2(N);

  typedef logic [N*DW-1:0] vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  vec_t       in_data = '0;
  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] exp_frame = 8'd0;

  always #5 clk = ~clk;

  layer_output_serializer_if #(.NEURON_NUMBER(N), .DATA_WIDTH(DW), .IDX_W(IW)) if0 ();
  layer_output_serializer_if #(.NEURON_NUMBER(N), .DATA_WIDTH(DW), .IDX_W(IW)) if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_data   = in_data;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.in_data   = in_data;
  assign if1.out_ready = out_ready;

  layer_output_serializer #(
    .NEURON_NUMBER(N), .DATA_WIDTH(DW), .RELU_EN(1'b0), .IDX_W(IW)
  ) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if0.slave)
  );

  layer_output_serializer #(
    .NEURON_NUMBER(N), .DATA_WIDTH(DW), .RELU_EN(1'b1), .IDX_W(IW)
  ) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if1.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input vec_t v);
    @(posedge clk); #1;
    in_data  = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Entered 1 time unit after the capture edge; stall selects the 1,0,0,1 ready pattern.
  task automatic stream_words(input vec_t exp0, input vec_t exp1, input bit stall,
                              input int n_xfer);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    while (k < n_xfer && cyc < 100) begin
      out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      @(negedge clk);
      check("valid", if0.out_valid, 1);
      check("busy", if0.busy, 1);
      check("in_ready_stream", if0.in_ready, 0);
      check("index0", if0.out_index, k);
      check("index1", if1.out_index, k);
      check("last", if0.out_last, (k == N - 1));
      check("data0", if0.out_data, exp0[DW*k +: DW]);
      check("data1", if1.out_data, exp1[DW*k +: DW]);
      if (out_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    check("xfer_count", k, n_xfer);
    check("cycles", cyc, stall ? 20 : n_xfer);
    if (n_xfer == N) begin
      exp_frame = exp_frame + 8'd1;
      @(negedge clk);
      check("idle_in_ready", if0.in_ready, 1);
      check("idle_valid", if0.out_valid, 0);
      check("idle_busy", if0.busy, 0);
      check("idle_index", if0.out_index, 0);
      check("idle_last", if0.out_last, 0);
      check("frame0", if0.frame_count, exp_frame);
      check("frame1", if1.frame_count, exp_frame);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t va;
    vec_t vr;
    vec_t vr1;
    vec_t vb;
    vec_t vc;

    for (int i = 0; i < N; i++) begin
      va[DW*i +: DW] = 16'(100 * (i + 1));
      vb[DW*i +: DW] = 16'(16'h1000 + 3 * i);
      vc[DW*i +: DW] = 16'(16'h0A00 + i);
    end
    vr           = {N{16'h0001}};
    vr[15:0]     = 16'h8000;
    vr[31:16]    = 16'hFFFF;
    vr[47:32]    = 16'h0000;
    vr[63:48]    = 16'h7FFF;
    vr[79:64]    = 16'h0800;
    vr1          = vr;
    vr1[15:0]    = 16'h0000;
    vr1[31:16]   = 16'h0000;

    // Reset values
    #12;
    check("rst_in_ready", if0.in_ready, 1);
    check("rst_valid", if0.out_valid, 0);
    check("rst_data", if0.out_data, 0);
    check("rst_index", if0.out_index, 0);
    check("rst_last", if0.out_last, 0);
    check("rst_busy", if0.busy, 0);
    check("rst_frame", if0.frame_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic stream, ReLU, back-pressure
    send(va);
    stream_words(va, va, 1'b0, N);
    send(vr);
    stream_words(vr, vr1, 1'b0, N);
    send(vb);
    stream_words(vb, vb, 1'b1, N);

    // Upstream hold-off: second vector presented throughout the first stream
    @(posedge clk); #1;
    in_data  = va;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_data  = vb;
    stream_words(va, va, 1'b0, N);
    @(posedge clk); #1;
    in_valid = 1'b0;
    stream_words(vb, vb, 1'b0, N);
    check("holdoff_frame", if0.frame_count, 8'd5);

    // Reset mid-stream after 4 transfers
    send(vc);
    stream_words(vc, vc, 1'b0, 4);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", if0.out_valid, 0);
    check("midrst_busy", if0.busy, 0);
    check("midrst_frame", if0.frame_count, 0);
    check("midrst_in_ready", if0.in_ready, 1);
    check("midrst_frame1", if1.frame_count, 0);
    exp_frame = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    send(va);
    stream_words(va, va, 1'b0, N);

    // Frame counter wrap after 256 vectors
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_frame = 8'd0;
    for (int j = 0; j < 256; j++) begin
      send(vc);
      stream_words(vc, vc, 1'b0, N);
      if (j == 254) check("frame_255", if0.frame_count, 8'd255);
    end
    check("frame_wrap", if0.frame_count, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
